packer_fsm: RTL and testbench

PACKER_FSM -- requirements
Module: packer_fsm

---
 rtl/packer_fsm.sv | 116 +++++++++++
 tb/tb_packer_fsm.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/packer_fsm.sv
// Packs 32-byte input beats into 160-byte chunks (up to 5 beats), framing packets with sop/eop
// and flagging protocol violations with a registered one-cycle error pulse.
module packer_fsm (
   input  logic          clk,
   input  logic          reset_L,
   input  logic          i_val,
   input  logic          i_sop,
   input  logic          i_eop,
   input  logic [7:0]    i_vbc,
   input  logic [255:0]  i_data,
   output logic          i_ready,
   input  logic          o_ready,
   output logic          o_val,
   output logic          o_sop,
   output logic          o_eop,
   output logic [7:0]    o_vbc,
   output logic [1279:0] o_data,
   output logic          o_err
);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StAcc  = 2'd1;
   localparam logic [1:0] StHold = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [2:0]    cnt_q, cnt_d;
   logic [7:0]    bytes_q, bytes_d;
   logic [1279:0] data_q, data_d;
   logic          sop_q, sop_d;
   logic          eop_q, eop_d;
   logic          err_q, err_d;

   logic          in_xfer;
   logic          out_xfer;
   logic          bad_beat;
   logic [10:0]   slot_base;

   assign o_val    = (state_q == StHold);
   assign i_ready  = reset_L && (!o_val || o_ready);
   assign in_xfer  = i_val && i_ready;
   assign out_xfer = o_val && o_ready;

   assign o_sop  = o_val && sop_q;
   assign o_eop  = o_val && eop_q;
   assign o_vbc  = o_val ? bytes_q : 8'd0;
   assign o_data = data_q;
   assign o_err  = err_q;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bytes_d   = bytes_q;
      data_d    = data_q;
      sop_d     = sop_q;
      eop_d     = eop_q;
      err_d     = 1'b0;
      bad_beat  = 1'b0;
      slot_base = '0;

      // Retire first so a beat taken in the same cycle sees a cleared accumulator.
      if (out_xfer) begin
         state_d = eop_q ? StIdle : StAcc;
         cnt_d   = 3'd0;
         bytes_d = 8'd0;
         data_d  = '0;
         sop_d   = 1'b0;
         eop_d   = 1'b0;
      end

      if (in_xfer && i_vbc != 8'd0) begin
         bad_beat = (i_vbc > 8'd32) || (!i_eop && i_vbc != 8'd32) ||
                    (state_d == StIdle && !i_sop);
         if (bad_beat) begin
            err_d = 1'b1;
         end else begin
            // A new sop inside an open packet abandons the partial chunk.
            if (i_sop) begin
               err_d   = (state_d == StAcc);
               cnt_d   = 3'd0;
               bytes_d = 8'd0;
               data_d  = '0;
            end
            if (cnt_d == 3'd0) begin
               sop_d = i_sop;
            end
            slot_base = {cnt_d, 8'd0};
            data_d[slot_base +: 256] = i_data;
            cnt_d   = cnt_d + 3'd1;
            bytes_d = bytes_d + i_vbc;
            eop_d   = i_eop;
            state_d = (i_eop || cnt_d == 3'd5) ? StHold : StAcc;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         state_q <= StIdle;
         cnt_q   <= 3'd0;
         bytes_q <= 8'd0;
         data_q  <= '0;
         sop_q   <= 1'b0;
         eop_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bytes_q <= bytes_d;
         data_q  <= data_d;
         sop_q   <= sop_d;
         eop_q   <= eop_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_packer_fsm.sv
// Bench for packer_fsm: directed scenarios plus randomized packets checked every cycle against a
// queue-based packet model.
module tb_packer_fsm;

   logic          clk = 1'b0;
   logic          reset_L = 1'b0;
   logic          i_val = 1'b0, i_sop = 1'b0, i_eop = 1'b0;
   logic [7:0]    i_vbc = 8'd0;
   logic [255:0]  i_data = '0;
   logic          i_ready;
   logic          o_ready = 1'b0;
   logic          o_val, o_sop, o_eop, o_err;
   logic [7:0]    o_vbc;
   logic [1279:0] o_data;

   int n_checks = 0;
   int n_fail   = 0;

   packer_fsm dut (
      .clk     (clk),
      .reset_L (reset_L),
      .i_val   (i_val),
      .i_sop   (i_sop),
      .i_eop   (i_eop),
      .i_vbc   (i_vbc),
      .i_data  (i_data),
      .i_ready (i_ready),
      .o_ready (o_ready),
      .o_val   (o_val),
      .o_sop   (o_sop),
      .o_eop   (o_eop),
      .o_vbc   (o_vbc),
      .o_data  (o_data),
      .o_err   (o_err)
   );

   always #5 clk = ~clk;

   // Model: expected registered outputs after the most recent edge.
   bit            m_val = 0, m_sop = 0, m_eop = 0, m_err = 0, m_open = 0;
   int            m_vbc = 0;
   logic [1279:0] m_data = '0;
   logic [255:0]  q_data[$];
   int            q_vbc[$];
   bit            q_first_sop = 0;

   // Bench-side packet generator
   bit gen_open = 0;
   int gen_rem  = 0;

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic void chk_data(string name, logic [1279:0] act, logic [1279:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         for (int s = 0; s < 5; s++) begin
            if (act[s*256 +: 256] !== exp[s*256 +: 256]) begin
               $display("FAIL %s slot=%0d actual=%h required=%h", name, s,
                        act[s*256 +: 256], exp[s*256 +: 256]);
               break;
            end
         end
      end
   endfunction

   function automatic logic [255:0] make_data(int vbc);
      logic [255:0] d;
      for (int b = 0; b < 32; b++) d[b*8 +: 8] = (b < vbc) ? 8'($urandom) : 8'h00;
      return d;
   endfunction

   function automatic void model_reset();
      m_val = 0; m_sop = 0; m_eop = 0; m_err = 0; m_open = 0;
      m_vbc = 0; m_data = '0;
      q_data.delete(); q_vbc.delete();
   endfunction

   function automatic void model_step(bit acc, bit sop, bit eop, int vbc, logic [255:0] data,
                                      bit ordy);
      m_err = 0;
      if (m_val && ordy) m_val = 0;
      if (!acc || vbc == 0) return;
      if (vbc > 32 || (!eop && vbc != 32) || (!m_open && !sop)) begin
         m_err = 1;
         return;
      end
      if (sop) begin
         if (m_open) m_err = 1;
         q_data.delete(); q_vbc.delete();
      end
      if (q_data.size() == 0) q_first_sop = sop;
      q_data.push_back(data);
      q_vbc.push_back(vbc);
      m_open = 1;
      if (eop || q_data.size() == 5) begin
         m_data = '0;
         m_vbc  = 0;
         foreach (q_data[k]) begin
            m_data[k*256 +: 256] = q_data[k];
            m_vbc += q_vbc[k];
         end
         m_sop  = q_first_sop;
         m_eop  = eop;
         m_val  = 1;
         m_open = !eop;
         q_data.delete(); q_vbc.delete();
      end
   endfunction

   // Compare process: outputs are stable at the falling edge.
   always @(negedge clk) begin
      chk("i_ready", i_ready, reset_L && (!m_val || o_ready));
      chk("o_val", o_val, m_val);
      chk("o_err", o_err, m_err);
      if (m_val) begin
         chk("o_sop", o_sop, m_sop);
         chk("o_eop", o_eop, m_eop);
         chk("o_vbc", o_vbc, 64'(m_vbc));
         chk_data("o_data", o_data, m_data);
      end
   end

   // Entered and left at a falling edge; one rising edge in between.
   task automatic step(input bit val, input bit sop, input bit eop, input int vbc,
                       input logic [255:0] data, input bit ordy, output bit acc);
      #1;
      i_val = val; i_sop = sop; i_eop = eop; i_vbc = 8'(vbc); i_data = data; o_ready = ordy;
      acc = val && reset_L && (!m_val || ordy);
      model_step(acc, sop, eop, vbc, data, ordy);
      @(negedge clk);
   endtask

   task automatic do_reset();
      #2;
      i_val = 0;
      reset_L = 0;
      model_reset();
      gen_open = 0;
      #1;
      chk("rst_o_val", o_val, 0);
      chk("rst_i_ready", i_ready, 0);
      chk("rst_o_vbc", o_vbc, 0);
      chk("rst_o_err", o_err, 0);
      chk_data("rst_o_data", o_data, '0);
      @(negedge clk);
      #1 reset_L = 1;
      #1 chk("rel_i_ready", i_ready, 1);
      @(negedge clk);
   endtask

   initial begin
      bit           acc, ordy, val, sop, eop, legal;
      int           kind, r, vbc;
      logic [255:0] d, d2;
      logic [1279:0] exp_data;

      repeat (2) @(negedge clk);
      chk("init_o_val", o_val, 0);
      chk("init_i_ready", i_ready, 0);
      #1 reset_L = 1;
      @(negedge clk);

      // Single sop+eop beat of 20 bytes
      d = make_data(20);
      step(1, 1, 1, 20, d, 1, acc);
      chk("t1_val", o_val, 1);
      chk("t1_sop", o_sop, 1);
      chk("t1_eop", o_eop, 1);
      chk("t1_vbc", o_vbc, 20);
      exp_data = '0;
      exp_data[159:0] = d[159:0];
      chk_data("t1_data", o_data, exp_data);

      // 200-byte packet: 160 + 40
      for (int b = 0; b < 7; b++) begin
         step(1, b == 0, b == 6, (b == 6) ? 8 : 32, make_data((b == 6) ? 8 : 32), 1, acc);
         if (b == 4) begin
            chk("t2_c1_vbc", o_vbc, 160);
            chk("t2_c1_sop", o_sop, 1);
            chk("t2_c1_eop", o_eop, 0);
         end
      end
      chk("t2_c2_vbc", o_vbc, 40);
      chk("t2_c2_sop", o_sop, 0);
      chk("t2_c2_eop", o_eop, 1);

      // Back-pressure in HOLD, then retire and accept in the same cycle
      step(1, 1, 1, 10, make_data(10), 1, acc);
      d2 = make_data(5);
      for (int c = 0; c < 10; c++) begin
         step(1, 1, 1, 5, d2, 0, acc);
         chk("t3_stall_ready", i_ready, 0);
         chk("t3_stall_vbc", o_vbc, 10);
      end
      step(1, 1, 1, 5, d2, 1, acc);
      chk("t3_new_val", o_val, 1);
      chk("t3_new_vbc", o_vbc, 5);

      // Protocol errors
      step(1, 1, 1, 40, make_data(32), 1, acc);
      chk("t4_big_err", o_err, 1);
      chk("t4_big_val", o_val, 0);
      step(0, 0, 0, 0, '0, 1, acc);
      chk("t4_err_pulse", o_err, 0);
      step(1, 0, 1, 10, make_data(10), 1, acc);
      chk("t4_nosop_err", o_err, 1);

      // sop inside open packet restarts
      step(1, 1, 0, 32, make_data(32), 1, acc);
      step(1, 0, 0, 32, make_data(32), 1, acc);
      step(1, 1, 1, 12, make_data(12), 1, acc);
      chk("t5_err", o_err, 1);
      chk("t5_val", o_val, 1);
      chk("t5_sop", o_sop, 1);
      chk("t5_vbc", o_vbc, 12);

      // Reset mid-ACC, then mid-HOLD
      step(1, 1, 0, 32, make_data(32), 1, acc);
      do_reset();
      repeat (3) step(0, 0, 0, 0, '0, 1, acc);
      step(1, 1, 1, 7, make_data(7), 0, acc);
      do_reset();
      repeat (3) step(0, 0, 0, 0, '0, 1, acc);

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         kind = $urandom_range(0, 99);
         ordy = ($urandom_range(0, 9) < 7);
         val  = ($urandom_range(0, 3) != 0);
         if (!gen_open || kind < 4) begin
            sop = 1;
            r   = $urandom_range(1, 400);
         end else begin
            sop = 0;
            r   = gen_rem;
         end
         vbc   = (r > 32) ? 32 : r;
         eop   = (r <= 32);
         legal = 1;
         if (kind >= 4 && kind < 7) begin
            vbc = $urandom_range(33, 255); legal = 0;
         end else if (kind >= 7 && kind < 10) begin
            vbc = 0; legal = 0;
         end else if (kind >= 10 && kind < 13) begin
            eop = 0; vbc = $urandom_range(1, 31); legal = 0;
         end else if (kind >= 13 && kind < 15 && !gen_open) begin
            sop = 0; legal = 0;
         end
         step(val, sop, eop, vbc, make_data(vbc), ordy, acc);
         if (acc && legal) begin
            gen_rem  = r - vbc;
            gen_open = !eop;
         end
         if (c % 1000 == 999) do_reset();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
